// File: rtl/pg_dispatch_if.sv
// pg_dispatch_if: metadata/match streams in, per-lane streams out, order FIFO and counters
interface pg_dispatch_if #(
  parameter int NUM_PG = 4,
  parameter int TAG_W = 2,
  parameter int META_W = 32
);
  logic              in_meta_valid;
  logic [META_W-1:0] in_meta_data;
  logic              in_meta_ready;
  logic              in_match_sop;
  logic              in_match_eop;
  logic [127:0]      in_match_data;
  logic [5:0]        in_match_empty;
  logic              in_match_valid;
  logic              in_match_ready;
  logic [NUM_PG-1:0] out_meta_valid;
  logic [META_W-1:0] out_meta_data;
  logic [NUM_PG-1:0] out_meta_ready;
  logic [NUM_PG-1:0] out_match_valid;
  logic              out_match_sop;
  logic              out_match_eop;
  logic [127:0]      out_match_data;
  logic [5:0]        out_match_empty;
  logic [NUM_PG-1:0] out_match_ready;
  logic [NUM_PG-1:0] lane_almost_full;
  logic [TAG_W-1:0]  order_tag;
  logic              order_valid;
  logic              order_ready;
  logic [31:0]       pkt_cnt;
  logic [31:0]       stall_cnt;
  modport master (
    output in_meta_valid, in_meta_data, in_match_sop, in_match_eop, in_match_data,
           in_match_empty, in_match_valid, out_meta_ready, out_match_ready,
           lane_almost_full, order_ready,
    input  in_meta_ready, in_match_ready, out_meta_valid, out_meta_data, out_match_valid,
           out_match_sop, out_match_eop, out_match_data, out_match_empty, order_tag,
           order_valid, pkt_cnt, stall_cnt
  );
  modport slave (
    input  in_meta_valid, in_meta_data, in_match_sop, in_match_eop, in_match_data,
           in_match_empty, in_match_valid, out_meta_ready, out_match_ready,
           lane_almost_full, order_ready,
    output in_meta_ready, in_match_ready, out_meta_valid, out_meta_data, out_match_valid,
           out_match_sop, out_match_eop, out_match_data, out_match_empty, order_tag,
           order_valid, pkt_cnt, stall_cnt
  );
endinterface

// File: rtl/pg_dispatch.sv
// pg_dispatch: round-robin packet steering across port-group lanes with an arrival-order FIFO
module pg_dispatch #(
  parameter int NUM_PG = 4,
  parameter int TAG_W = 2,
  parameter int ORDER_DEPTH = 16,
  parameter int META_W = 32
) (
  input logic clk,
  input logic rst,
  pg_dispatch_if.slave bus
);
  localparam int AW = $clog2(ORDER_DEPTH);
  typedef enum logic {IDLE, MATCH} state_t;
  state_t r_state, w_next;
  logic [TAG_W-1:0] r_rr, r_sel, w_grant, w_idx;
  logic [NUM_PG-1:0] w_elig;
  logic w_any, w_full, w_grant_ok, w_push, w_pop, w_beat, w_stall;
  logic [TAG_W-1:0] r_fifo [ORDER_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic [31:0] r_pkt, r_stall;
  // first eligible lane scanning upward from the round-robin pointer
  always_comb begin
    w_elig = bus.out_meta_ready & ~bus.lane_almost_full;
    w_any = 1'b0;
    w_grant = '0;
    w_idx = '0;
    for (int k = NUM_PG - 1; k >= 0; k--) begin
      w_idx = TAG_W'((int'(r_rr) + k) % NUM_PG);
      if (w_elig[w_idx]) begin
        w_any = 1'b1;
        w_grant = w_idx;
      end
    end
  end
  assign w_full = r_cnt == (AW+1)'(ORDER_DEPTH);
  assign w_grant_ok = w_any & ~w_full;
  assign w_push = (r_state == IDLE) & bus.in_meta_valid & w_grant_ok;
  assign w_stall = (r_state == IDLE) & bus.in_meta_valid & ~w_grant_ok;
  assign w_pop = (r_cnt != '0) & bus.order_ready;
  assign w_beat = (r_state == MATCH) & bus.in_match_valid & bus.out_match_ready[r_sel];
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // leave IDLE on metadata handshake, return after the eop beat is taken
  always_comb
    w_next = (r_state == IDLE) ? (w_push ? MATCH : IDLE) : ((w_beat & bus.in_match_eop) ? IDLE : MATCH);
  // handshake and lane-steering outputs, all quiet while reset is held
  always_comb begin
    bus.in_meta_ready = ~rst & (r_state == IDLE) & w_grant_ok;
    bus.out_meta_valid = (bus.in_meta_ready & bus.in_meta_valid) ? NUM_PG'(1) << w_grant : '0;
    bus.in_match_ready = ~rst & (r_state == MATCH) & bus.out_match_ready[r_sel];
    bus.out_match_valid = (~rst & (r_state == MATCH) & bus.in_match_valid) ? NUM_PG'(1) << r_sel : '0;
  end
  assign bus.out_meta_data = bus.in_meta_data;
  assign bus.out_match_sop = bus.in_match_sop;
  assign bus.out_match_eop = bus.in_match_eop;
  assign bus.out_match_data = bus.in_match_data;
  assign bus.out_match_empty = bus.in_match_empty;
  assign bus.order_valid = r_cnt != '0;
  assign bus.order_tag = r_fifo[r_rp];
  assign bus.pkt_cnt = r_pkt;
  assign bus.stall_cnt = r_stall;
  // latch the granted lane, advance the pointer past it, count packets and stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rr <= '0;
      r_sel <= '0;
      r_pkt <= '0;
      r_stall <= '0;
    end else begin
      if (w_push) begin
        r_sel <= w_grant;
        r_rr <= (w_grant == TAG_W'(NUM_PG - 1)) ? '0 : w_grant + 1'b1;
        r_pkt <= r_pkt + 1'b1;
      end
      if (w_stall & ~&r_stall) r_stall <= r_stall + 1'b1;
    end
  // order FIFO storage holds only lane ids, so it is left unreset
  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wp] <= w_grant;
  // order FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: tb/tb_pg_dispatch.sv
// tb_pg_dispatch: randomized and directed scoreboard bench for pg_dispatch
module tb_pg_dispatch;
  localparam int NP = 4, TW = 2, OD = 4, MW = 32;
  typedef struct packed {logic [127:0] d; logic sop; logic eop; logic [5:0] e;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pg_dispatch_if #(.NUM_PG(NP), .TAG_W(TW), .META_W(MW)) bus();
  pg_dispatch #(.NUM_PG(NP), .TAG_W(TW), .ORDER_DEPTH(OD), .META_W(MW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [MW-1:0] exp_meta[$];
  beat_t exp_beat[$];
  int exp_order[$];
  int checks = 0, errors = 0;
  int m_rr = 0, m_lane = 0, m_pkt = 0, m_stall = 0, obs_lane = -1;
  bit m_idle = 1'b1, rnd = 1'b0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  // reference model: expected lane from the round-robin rule, stall and order bookkeeping
  always @(negedge clk) if (!rst) begin
    int g;
    bit ok;
    logic [NP-1:0] el;
    beat_t b;
    el = bus.out_meta_ready & ~bus.lane_almost_full;
    g = -1;
    for (int d = 0; d < NP; d++)
      if (g < 0 && el[TW'((m_rr + d) % NP)]) g = (m_rr + d) % NP;
    ok = (g >= 0) && (exp_order.size() < OD);
    chk("pkt_cnt", bus.pkt_cnt, m_pkt);
    chk("stall_cnt", bus.stall_cnt, m_stall);
    chk("order_valid", bus.order_valid, exp_order.size() != 0);
    if (exp_order.size() != 0) begin
      chk("order_tag", bus.order_tag, exp_order[0]);
      if (bus.order_ready) void'(exp_order.pop_front());
    end
    if (m_idle) begin
      chk("in_meta_ready", bus.in_meta_ready, ok);
      chk("in_match_ready_idle", bus.in_match_ready, 0);
      chk("out_match_valid_idle", bus.out_match_valid, 0);
      chk("out_meta_valid", bus.out_meta_valid, (bus.in_meta_valid && ok) ? (1 << g) : 0);
      if (bus.in_meta_valid && ok) begin
        chk("meta_queue", exp_meta.size(), 1);
        if (exp_meta.size() != 0) chk("out_meta_data", bus.out_meta_data, exp_meta.pop_front());
        for (int i = 0; i < NP; i++) if (bus.out_meta_valid[i]) obs_lane = i;
        m_rr = (g + 1) % NP;
        m_lane = g;
        m_pkt++;
        exp_order.push_back(g);
        m_idle = 1'b0;
      end else if (bus.in_meta_valid) m_stall++;
    end else begin
      chk("in_meta_ready_match", bus.in_meta_ready, 0);
      chk("out_meta_valid_match", bus.out_meta_valid, 0);
      chk("out_match_valid", bus.out_match_valid, bus.in_match_valid ? (1 << m_lane) : 0);
      chk("in_match_ready", bus.in_match_ready, bus.out_match_ready[TW'(m_lane)]);
      if (bus.in_match_valid && bus.out_match_ready[TW'(m_lane)]) begin
        chk("beat_queue", exp_beat.size() != 0, 1);
        if (exp_beat.size() != 0) begin
          b = exp_beat.pop_front();
          chk("out_match_data", bus.out_match_data, b.d);
          chk("out_match_sop", bus.out_match_sop, b.sop);
          chk("out_match_eop", bus.out_match_eop, b.eop);
          chk("out_match_empty", bus.out_match_empty, b.e);
          if (b.eop) m_idle = 1'b1;
        end
      end
    end
  end
  // randomized lane back-pressure and order consumer
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd) begin
      bus.out_meta_ready = NP'($urandom);
      bus.lane_almost_full = NP'($urandom) & NP'($urandom);
      bus.out_match_ready = NP'($urandom | $urandom);
      bus.order_ready = 1'($urandom_range(0, 1));
    end
  end
  task automatic wait_rdy(input bit beat);
    int t = 0;
    do begin
      @(negedge clk);
      if (++t > 2000) begin
        errors++;
        $display("FAIL ready_timeout got 0 want 1 (beat=%0d)", beat);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "ready wait expired");
      end
    end while (!(beat ? bus.in_match_ready : bus.in_meta_ready));
    @(posedge clk);
    #1;
  endtask
  task automatic drive_meta();
    logic [MW-1:0] m;
    m = $urandom;
    exp_meta.push_back(m);
    bus.in_meta_data = m;
    bus.in_meta_valid = 1'b1;
  endtask
  task automatic send_meta();
    drive_meta();
    wait_rdy(0);
    bus.in_meta_valid = 1'b0;
  endtask
  task automatic drive_beat(input bit sop, input bit eop);
    beat_t b;
    b.d = {$urandom, $urandom, $urandom, $urandom};
    b.sop = sop;
    b.eop = eop;
    b.e = eop ? 6'($urandom_range(0, 15)) : 6'd0;
    exp_beat.push_back(b);
    bus.in_match_data = b.d;
    bus.in_match_sop = sop;
    bus.in_match_eop = eop;
    bus.in_match_empty = b.e;
    bus.in_match_valid = 1'b1;
  endtask
  task automatic send_beat(input bit sop, input bit eop);
    drive_beat(sop, eop);
    wait_rdy(1);
    bus.in_match_valid = 1'b0;
  endtask
  task automatic send_pkt(input int n);
    send_meta();
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(i == 0, i == n - 1);
    end
  endtask
  initial begin
    int s0;
    bus.in_meta_valid = 1'b1;
    bus.in_meta_data = '0;
    bus.in_match_valid = 1'b0;
    bus.in_match_sop = 1'b0;
    bus.in_match_eop = 1'b0;
    bus.in_match_data = '0;
    bus.in_match_empty = '0;
    bus.out_meta_ready = '1;
    bus.out_match_ready = '1;
    bus.lane_almost_full = '0;
    bus.order_ready = 1'b1;
    #1;
    chk("rst_in_meta_ready", bus.in_meta_ready, 0);
    chk("rst_out_meta_valid", bus.out_meta_valid, 0);
    chk("rst_order_valid", bus.order_valid, 0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    bus.in_meta_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_pkt(1);
      chk("rr_lane", obs_lane, i % NP);
    end
    chk("five_pkt_cnt", bus.pkt_cnt, 5);
    bus.lane_almost_full = 4'b0010;
    send_pkt(1);
    chk("skip_af_lane", obs_lane, 2);
    send_pkt(1);
    chk("after_skip_lane", obs_lane, 3);
    bus.lane_almost_full = 4'b1011;
    send_meta();
    chk("multi_beat_lane", obs_lane, 2);
    bus.lane_almost_full = '0;
    send_beat(1, 0);
    bus.out_match_ready = 4'b1011;
    drive_beat(0, 0);
    repeat (2) begin
      @(negedge clk);
      chk("beat2_held", bus.in_match_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.out_match_ready = '1;
    wait_rdy(1);
    bus.in_match_valid = 1'b0;
    send_beat(0, 1);
    @(negedge clk);
    chk("idle_after_eop", bus.in_meta_ready, 1);
    @(posedge clk);
    #1;
    bus.order_ready = 1'b0;
    for (int i = 0; i < OD; i++) send_pkt(1);
    drive_meta();
    @(negedge clk);
    chk("full_hold", bus.in_meta_ready, 0);
    s0 = bus.stall_cnt;
    repeat (2) begin
      @(negedge clk);
      chk("full_hold", bus.in_meta_ready, 0);
    end
    chk("full_stall_delta", bus.stall_cnt - s0, 2);
    @(posedge clk);
    #1;
    bus.order_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.order_ready = 1'b0;
    @(negedge clk);
    chk("accept_after_pop", bus.in_meta_ready, 1);
    @(posedge clk);
    #1;
    bus.in_meta_valid = 1'b0;
    send_beat(1, 1);
    bus.order_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.out_meta_ready = '0;
    drive_meta();
    s0 = bus.stall_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("no_ready_stall", bus.stall_cnt - s0, 10);
    bus.out_meta_ready = '1;
    wait_rdy(0);
    bus.in_meta_valid = 1'b0;
    send_beat(1, 1);
    bus.order_ready = 1'b0;
    send_meta();
    send_beat(1, 0);
    drive_beat(0, 0);
    chk("pre_rst_order_valid", bus.order_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_order_valid", bus.order_valid, 0);
    chk("mid_rst_pkt_cnt", bus.pkt_cnt, 0);
    chk("mid_rst_out_match_valid", bus.out_match_valid, 0);
    chk("mid_rst_in_match_ready", bus.in_match_ready, 0);
    bus.in_match_valid = 1'b0;
    exp_beat.delete();
    exp_meta.delete();
    exp_order.delete();
    m_rr = 0;
    m_idle = 1'b1;
    m_pkt = 0;
    m_stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.order_ready = 1'b1;
    send_pkt(1);
    chk("post_rst_lane", obs_lane, 0);
    rnd = 1'b1;
    repeat (150) send_pkt($urandom_range(1, 4));
    rnd = 1'b0;
    bus.out_meta_ready = '1;
    bus.out_match_ready = '1;
    bus.lane_almost_full = '0;
    bus.order_ready = 1'b1;
    repeat (OD + 4) @(posedge clk);
    #1;
    chk("final_pkt_cnt", bus.pkt_cnt, m_pkt);
    chk("final_order_valid", bus.order_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
